// File: rtl/mult_pkg.sv
// Shared widths and mode encodings for the 8x8 multiplier and its 4x4 partial-product cells.
package mult_pkg;

  // Operand, nibble, partial-product and result widths.
  localparam int W_OP   = 8;
  localparam int W_NIB  = 4;
  localparam int W_PART = 2 * W_NIB;
  localparam int W_RES  = 16;

  // Mode input encodings.
  localparam logic MODE_8X8      = 1'b0;
  localparam logic MODE_DUAL_4X4 = 1'b1;

endpackage

// File: rtl/mult_4x4.sv
// 4x4 multiplier cell with an independent signed flag per operand; 8-bit product.
module mult_4x4
  import mult_pkg::*;
(
  input  logic [W_NIB-1:0]  i_a,
  input  logic [W_NIB-1:0]  i_b,
  input  logic              i_a_signed,
  input  logic              i_b_signed,
  output logic [W_PART-1:0] o_p
);

  logic [W_PART-1:0] w_a_ext;
  logic [W_PART-1:0] w_b_ext;

  // Extending to the product width first makes the truncated product exact for every
  // signed/unsigned combination: all results fit in 8 bits.
  assign w_a_ext = {{W_NIB{i_a_signed & i_a[W_NIB-1]}}, i_a};
  assign w_b_ext = {{W_NIB{i_b_signed & i_b[W_NIB-1]}}, i_b};
  assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/multiplier_8x8.sv
// Registered 8x8 multiplier (signed/unsigned) that can also run as two independent 4x4 lanes.
// Free-running datapath: no valid/ready handshake, one product per cycle, latency 1.
module multiplier_8x8
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [W_OP-1:0]   In_1,
  input  logic [W_OP-1:0]   In_2,
  input  logic              Sign,
  input  logic              Mode,
  output logic [W_RES-1:0]  Result
);

  logic [W_PART-1:0] w_hh;
  logic [W_PART-1:0] w_hl;
  logic [W_PART-1:0] w_lh;
  logic [W_PART-1:0] w_ll;
  logic              w_dual;
  logic              w_ll_signed;
  logic [W_RES-1:0]  w_hh_ext;
  logic [W_RES-1:0]  w_hl_ext;
  logic [W_RES-1:0]  w_lh_ext;
  logic [W_RES-1:0]  w_ll_ext;
  logic [W_RES-1:0]  w_prod_wide;
  logic [W_RES-1:0]  w_prod;
  logic [W_RES-1:0]  r_result;

  assign w_dual      = (Mode == MODE_DUAL_4X4);
  // The low nibbles are only signed when they are a lane of their own.
  assign w_ll_signed = Sign & w_dual;

  mult_4x4 u_hh (
    .i_a        (In_1[W_OP-1:W_NIB]),
    .i_b        (In_2[W_OP-1:W_NIB]),
    .i_a_signed (Sign),
    .i_b_signed (Sign),
    .o_p        (w_hh)
  );

  mult_4x4 u_hl (
    .i_a        (In_1[W_OP-1:W_NIB]),
    .i_b        (In_2[W_NIB-1:0]),
    .i_a_signed (Sign),
    .i_b_signed (1'b0),
    .o_p        (w_hl)
  );

  mult_4x4 u_lh (
    .i_a        (In_1[W_NIB-1:0]),
    .i_b        (In_2[W_OP-1:W_NIB]),
    .i_a_signed (1'b0),
    .i_b_signed (Sign),
    .o_p        (w_lh)
  );

  mult_4x4 u_ll (
    .i_a        (In_1[W_NIB-1:0]),
    .i_b        (In_2[W_NIB-1:0]),
    .i_a_signed (w_ll_signed),
    .i_b_signed (w_ll_signed),
    .o_p        (w_ll)
  );

  // Partials involving a signed high nibble are themselves signed; LL is unsigned in 8x8 mode.
  assign w_hh_ext = {{(W_RES - W_PART){Sign & w_hh[W_PART-1]}}, w_hh};
  assign w_hl_ext = {{(W_RES - W_PART){Sign & w_hl[W_PART-1]}}, w_hl};
  assign w_lh_ext = {{(W_RES - W_PART){Sign & w_lh[W_PART-1]}}, w_lh};
  assign w_ll_ext = {{(W_RES - W_PART){1'b0}}, w_ll};

  assign w_prod_wide = (w_hh_ext << W_OP)
                     + ((w_hl_ext + w_lh_ext) << W_NIB)
                     + w_ll_ext;

  assign w_prod = w_dual ? {w_hh, w_ll} : w_prod_wide;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else begin
      r_result <= w_prod;
    end
  end

  assign Result = r_result;

endmodule

// File: tb/tb_multiplier_8x8.sv
// Directed and randomised checks of multiplier_8x8 against hand-computed values and a reference model.
module tb_multiplier_8x8;

  logic        clk;
  logic        rst;
  logic [7:0]  In_1;
  logic [7:0]  In_2;
  logic        Sign;
  logic        Mode;
  logic [15:0] Result;

  int n_total;
  int n_bad;

  multiplier_8x8 dut (
    .clk    (clk),
    .rst    (rst),
    .In_1   (In_1),
    .In_2   (In_2),
    .Sign   (Sign),
    .Mode   (Mode),
    .Result (Result)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s, input logic m);
    In_1 = a;
    In_2 = b;
    Sign = s;
    Mode = m;
  endtask

  // Drive one vector, clock it in, check the registered result.
  task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic m, input logic [15:0] exp);
    drive(a, b, s, m);
    tick();
    check(tag, Result, exp);
  endtask

  function automatic logic [7:0] ref_nib(input logic [3:0] x, input logic [3:0] y, input logic s);
    int ix;
    int iy;
    int p;
    ix = s ? int'($signed(x)) : int'(x);
    iy = s ? int'($signed(y)) : int'(y);
    p = ix * iy;
    return p[7:0];
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s, input logic m);
    int ia;
    int ib;
    int p;
    if (m) begin
      return {ref_nib(a[7:4], b[7:4], s), ref_nib(a[3:0], b[3:0], s)};
    end
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p = ia * ib;
    return p[15:0];
  endfunction

  typedef struct {
    string       tag;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic        m;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    drive(8'hFF, 8'hFF, 1'b0, 1'b0);

    // Reset overrides live operands.
    tick();
    check("reset_state", Result, 16'h0000);
    tick();
    check("reset_hold", Result, 16'h0000);
    rst = 1'b0;

    // Hand-computed directed vectors.
    vecs.push_back('{"u_ff_ff",        8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01});
    vecs.push_back('{"s_m1_x2",        8'hFF, 8'h02, 1'b1, 1'b0, 16'hFFFE});
    vecs.push_back('{"s_m128_m128",    8'h80, 8'h80, 1'b1, 1'b0, 16'h4000});
    vecs.push_back('{"d_u_f3_25",      8'hF3, 8'h25, 1'b0, 1'b1, 16'h1E0F});
    vecs.push_back('{"d_s_f3_25",      8'hF3, 8'h25, 1'b1, 1'b1, 16'hFE0F});
    vecs.push_back('{"u_zero",         8'h00, 8'hAB, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{"s_7f_7f",        8'h7F, 8'h7F, 1'b1, 1'b0, 16'h3F01});
    vecs.push_back('{"s_m1_m1",        8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001});
    vecs.push_back('{"s_m128_7f",      8'h80, 8'h7F, 1'b1, 1'b0, 16'hC080});
    vecs.push_back('{"d_s_m8_m8",      8'h88, 8'h88, 1'b1, 1'b1, 16'h4040});
    vecs.push_back('{"d_u_ff_ff",      8'hFF, 8'hFF, 1'b0, 1'b1, 16'hE1E1});
    vecs.push_back('{"u_12_34",        8'h12, 8'h34, 1'b0, 1'b0, 16'h03A8});
    foreach (vecs[i]) begin
      apply(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].exp);
    end

    // Stable inputs keep the result.
    tick();
    check("hold_stable", Result, 16'h03A8);

    // Reset mid-stream discards the product, then first edge after it captures normally.
    drive(8'hFF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_stream", Result, 16'h0000);
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    check("rst_with_12_34", Result, 16'h0000);
    rst = 1'b0;
    tick();
    check("post_rst_12_34", Result, 16'h03A8);

    // Random sweep: one vector per cycle, each combination of Sign and Mode.
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 10; k++) begin
          logic [7:0] a;
          logic [7:0] b;
          a = 8'($urandom_range(0, 255));
          b = 8'($urandom_range(0, 255));
          apply($sformatf("sweep_s%0d_m%0d_%0d", s, m, k), a, b, 1'(s), 1'(m),
                ref_mul(a, b, 1'(s), 1'(m)));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplier_8x8.md
MULTIPLIER_8X8 -- requirements
Module: multiplier_8x8

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be as follows:
- clk, input, 1 bit: rising-edge clock.
- rst, input, 1 bit: synchronous active-high reset.
- In_1, input, 8 bits: operand A.
- In_2, input, 8 bits: operand B.
- Sign, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
- Mode, input, 1 bit: 0 = one 8x8 product, 1 = two independent 4x4 products.
- Result, output, 16 bits: registered product.
REQ-003 The block SHALL have no parameters; all widths are fixed.

Function
REQ-004 Mode=0, Sign=0: Result SHALL be the unsigned In_1*In_2, 16 bits, exact, no overflow possible.
REQ-005 Mode=0, Sign=1: Result SHALL be the signed In_1*In_2, as a 16-bit two's-complement value; -128*-128 gives 0x4000.
REQ-006 Mode=1: Result[15:8] SHALL be In_1[7:4]*In_2[7:4], and Result[7:0] SHALL be In_1[3:0]*In_2[3:0].
REQ-007 In Mode=1, each lane SHALL be independent, 8 bits wide, with no carry between lanes.
REQ-008 In Mode=1, Sign SHALL apply to both lanes: each nibble is signed when Sign=1 and unsigned when Sign=0.
REQ-009 Inputs SHALL be sampled on each rising clk edge, and Result SHALL show that product after that edge (latency 1 cycle, throughput 1 per cycle, no handshake).
REQ-010 Mode and Sign SHALL be sampled on the same edge as the operands; changing them on any cycle affects only that cycle's product.
REQ-011 Result SHALL hold its value while the inputs are stable; there is no enable.
REQ-012 There SHALL be no X-propagation beyond the sampled inputs; all internal logic is fully combinational between the input sample point and the output register.

Reset
REQ-013 While rst=1 at a rising edge, Result SHALL be 0x0000, overriding any operands.
REQ-014 Reset SHALL act only on clock edges, with no asynchronous path.
REQ-015 On the first edge with rst=0, the current inputs SHALL be captured normally.
REQ-016 Reset asserted mid-stream SHALL discard the in-flight product.

Structure
REQ-017 The 8x8 product SHALL be built from four instances of sub-module mult_4x4, each producing an 8-bit product with independent per-operand signed flags.
REQ-018 The four mult_4x4 instances SHALL be:
- HH: both operands signed when Sign=1.
- HL: In_1[7:4] signed when Sign=1, In_2[3:0] unsigned.
- LH: In_1[3:0] unsigned, In_2[7:4] signed when Sign=1.
- LL: both operands unsigned in 8x8 mode; signed when Mode=1 and Sign=1.
REQ-019 In Mode=0, the 8x8 product SHALL be formed by sign- or zero-extending the partials and summing HH<<8 + (HL+LH)<<4 + LL.
REQ-020 In Mode=1, Result SHALL be {HH, LL}, with HL and LH ignored.
REQ-021 Mode encodings and the widths 8, 4 and 16 SHALL be constants in the shared package mult_pkg; no typedefs are needed.

Verification
REQ-022 Scenario: Mode=0, Sign=0, In_1=0xFF, In_2=0xFF -> Result=0xFE01 one cycle later.
REQ-023 Scenario: Mode=0, Sign=1:
- In_1=0xFF, In_2=0x02 -> Result=0xFFFE.
- In_1=0x80, In_2=0x80 -> Result=0x4000.
REQ-024 Scenario: Mode=1, In_1=0xF3, In_2=0x25:
- Sign=0 -> Result=0x1E0F.
- Sign=1 -> Result=0xFE0F.
REQ-025 Scenario: rst=1 for one edge while In_1=0x12, In_2=0x34 -> Result=0x0000; after rst drops, the next edge gives Result=0x03A8.
REQ-026 Scenario: random sweep of 10 vectors each for Sign=1 and Sign=0, both Modes, one vector per cycle -> every Result matches a reference model, delayed by exactly 1 cycle.
